// File: rtl/kernel_ctrl_s_axi_gen.sv
// AXI4-Lite control slave: ap_ctrl block handshake, done/ready interrupts and a bank of 64-bit kernel arguments.
// Optional feature macro: KERNEL_CTRL_AUTO_RESTART_EN (implements AP_CTRL bit7 auto_restart).
module kernel_ctrl_s_axi_gen #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_ARGS   = 5
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      aclk_en,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [C_ADDR_WIDTH-1:0]   awaddr,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [C_DATA_WIDTH-1:0]   wdata,
  input  logic [C_DATA_WIDTH/8-1:0] wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [C_ADDR_WIDTH-1:0]   araddr,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [C_DATA_WIDTH-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      interrupt,
  output logic                      ap_start,
  input  logic                      ap_idle,
  input  logic                      ap_done,
  input  logic                      ap_ready,
  output logic [64*C_NUM_ARGS-1:0]  args
);
  localparam int WW = C_ADDR_WIDTH - 2;
  localparam int WE = WW + 1;
  localparam logic [WW:0] W_END = WE'(4 + 2 * C_NUM_ARGS);

  localparam logic [1:0] WRIDLE  = 2'd0;
  localparam logic [1:0] WRDATA  = 2'd1;
  localparam logic [1:0] WRRESP  = 2'd2;
  localparam logic [1:0] WRRESET = 2'd3;
  localparam logic [1:0] RDIDLE  = 2'd0;
  localparam logic [1:0] RDDATA  = 2'd1;
  localparam logic [1:0] RDRESET = 2'd2;

  logic [1:0]              wstate_q, wstate_d, rstate_q, rstate_d;
  logic [WW-1:0]           waddr_q, rword;
  logic [1:0]              bresp_q, rresp_q;
  logic [C_DATA_WIDTH-1:0] rdata_q, rmux;
  logic                    start_q, start_d, done_q, done_d, auto_q, auto_d, gie_q, gie_d;
  logic [1:0]              ier_q, ier_d, isr_q, isr_d;
  logic [63:0]             args_q [C_NUM_ARGS];
  logic [63:0]             args_d [C_NUM_ARGS];
  logic                    aw_hs, w_hs, ar_hs, wr_ctrl_en, rd_ctrl;
  logic                    unused_addr_lsbs;

  // Everything from 0x000 up to the last argument word is mapped; the rest answers SLVERR.
  function automatic logic is_mapped(input logic [WW-1:0] w);
    return {1'b0, w} < W_END;
  endfunction

  assign rword            = araddr[C_ADDR_WIDTH-1:2];
  assign unused_addr_lsbs = &{1'b0, awaddr[1:0], araddr[1:0]};
  assign aw_hs            = awvalid & awready;
  assign w_hs             = wvalid & wready;
  assign ar_hs            = arvalid & arready;
  assign wr_ctrl_en       = w_hs && wstrb[0] && (waddr_q == '0);
  assign rd_ctrl          = ar_hs && (rword == '0);

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      WRIDLE:  if (awvalid) wstate_d = WRDATA;
      WRDATA:  if (wvalid)  wstate_d = WRRESP;
      WRRESP:  if (bready)  wstate_d = WRIDLE;
      default: wstate_d = WRIDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      RDIDLE:  if (arvalid) rstate_d = RDDATA;
      RDDATA:  if (rready)  rstate_d = RDIDLE;
      default: rstate_d = RDIDLE;
    endcase
  end

  // Register next-state: kernel events first, host writes override where they must win.
  always_comb begin
    start_d = start_q;
    auto_d  = auto_q;
    done_d  = done_q;
    gie_d   = gie_q;
    ier_d   = ier_q;
    isr_d   = isr_q;
    args_d  = args_q;
    if (ap_ready && !auto_q) start_d = 1'b0;
    if (wr_ctrl_en && wdata[0]) start_d = 1'b1;
`ifdef KERNEL_CTRL_AUTO_RESTART_EN
    if (wr_ctrl_en) auto_d = wdata[7];
`endif
    if (rd_ctrl) done_d = 1'b0;
    if (ap_done) done_d = 1'b1;
    if (w_hs && wstrb[0] && waddr_q == WW'(1)) gie_d = wdata[0];
    if (w_hs && wstrb[0] && waddr_q == WW'(2)) ier_d = wdata[1:0];
    if (w_hs && wstrb[0] && waddr_q == WW'(3)) isr_d = isr_q ^ wdata[1:0];
    isr_d = isr_d | (ier_q & {ap_ready, ap_done});
    for (int i = 0; i < C_NUM_ARGS; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_hs && wstrb[b] && waddr_q == WW'(4 + 2 * i)) args_d[i][8*b +: 8] = wdata[8*b +: 8];
        if (w_hs && wstrb[b] && waddr_q == WW'(5 + 2 * i)) args_d[i][32+8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rmux = '0;
    if (rword == WW'(0)) rmux = C_DATA_WIDTH'({auto_q, 3'b000, ap_ready, ap_idle, done_q, start_q});
    if (rword == WW'(1)) rmux = C_DATA_WIDTH'(gie_q);
    if (rword == WW'(2)) rmux = C_DATA_WIDTH'(ier_q);
    if (rword == WW'(3)) rmux = C_DATA_WIDTH'(isr_q);
    for (int i = 0; i < C_NUM_ARGS; i++) begin
      if (rword == WW'(4 + 2 * i)) rmux = C_DATA_WIDTH'(args_q[i][31:0]);
      if (rword == WW'(5 + 2 * i)) rmux = C_DATA_WIDTH'(args_q[i][63:32]);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q <= WRRESET;
      rstate_q <= RDRESET;
      bresp_q  <= '0;
      rresp_q  <= '0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      auto_q   <= 1'b0;
      gie_q    <= 1'b0;
      ier_q    <= '0;
      isr_q    <= '0;
      for (int i = 0; i < C_NUM_ARGS; i++) args_q[i] <= '0;
    end else if (aclk_en) begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      if (w_hs) bresp_q <= is_mapped(waddr_q) ? 2'b00 : 2'b10;
      if (ar_hs) begin
        rdata_q <= rmux;
        rresp_q <= is_mapped(rword) ? 2'b00 : 2'b10;
      end
      start_q <= start_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
      gie_q   <= gie_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
      args_q  <= args_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aclk_en && aw_hs) waddr_q <= awaddr[C_ADDR_WIDTH-1:2];
  end

  assign awready   = (wstate_q == WRIDLE);
  assign wready    = (wstate_q == WRDATA);
  assign bvalid    = (wstate_q == WRRESP);
  assign bresp     = bresp_q;
  assign arready   = (rstate_q == RDIDLE);
  assign rvalid    = (rstate_q == RDDATA);
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign ap_start  = start_q;
  assign interrupt = gie_q & (|isr_q);

  for (genvar g = 0; g < C_NUM_ARGS; g++) begin : g_args
    assign args[64*g +: 64] = args_q[g];
  end
endmodule

// File: doc/kernel_ctrl_s_axi_gen.md
# kernel_ctrl_s_axi_gen

Parametrised AXI4-Lite control slave for RTL kernels: block-level handshake (ap_start/ap_done/ap_idle/ap_ready), interrupt logic, and a configurable bank of 64-bit kernel arguments. It sits between the host-facing AXI4-Lite control port and the kernel core, and replaces per-kernel fixed-argument control slaves. Compared with fixed-argument slaves, it adds an ap_ready interrupt channel, optional auto-restart, and SLVERR responses on unmapped addresses.

## Interface
- C_ADDR_WIDTH, 12: AXI address width; must satisfy 16 + 8*C_NUM_ARGS <= 2**C_ADDR_WIDTH.
- C_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_NUM_ARGS, 5: number of 64-bit arguments, 1..64.
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- aclk_en  in  1  global clock enable; all state holds when low.
- awvalid/awready, awaddr[C_ADDR_WIDTH]  in/out/in: write address channel.
- wvalid/wready, wdata[32], wstrb[4]  in/out/in/in: write data channel.
- bvalid/bready, bresp[2]  out/in/out: write response channel.
- arvalid/arready, araddr[C_ADDR_WIDTH]  in/out/in: read address channel.
- rvalid/rready, rdata[32], rresp[2]  out/in/out/out: read data channel.
- interrupt  out  1  level interrupt.
- ap_start  out  1  kernel start.
- ap_idle, ap_done, ap_ready  in  1 each  kernel status, each a 1-cycle pulse except ap_idle.
- args  out  64*C_NUM_ARGS  argument i is args[64*i +: 64].

## Operation
- Register map:
  - 0x000 AP_CTRL: bit0 start (R/W, clear on handshake), bit1 done (clear on read), bit2 idle (R), bit3 ready (R, live), bit7 auto_restart (R/W).
  - 0x004 GIE: bit0.
  - 0x008 IER: bits[1:0]; ch0 = ap_done, ch1 = ap_ready.
  - 0x00C ISR: bits[1:0], toggle on write.
  - Argument i: low word at 0x010+8*i, high word at 0x014+8*i.
- Argument writes honour wstrb byte-wise; all reset values are 0.
- Write FSM: WRRESET -> WRIDLE -> (awvalid) WRDATA -> (wvalid) WRRESP -> (bready) WRIDLE.
  - awready = WRIDLE, wready = WRDATA, bvalid = WRRESP.
  - waddr is captured on the AW handshake.
- Read FSM: RDRESET -> RDIDLE -> (arvalid) RDDATA -> (rvalid & rready) RDIDLE.
  - arready = RDIDLE, rvalid = RDDATA.
  - rdata and rresp are registered on the AR handshake.
- Address decode uses the full address; bits[1:0] are ignored.
- Unmapped address:
  - Write is discarded; bresp = 2'b10.
  - Read returns rdata = 0, rresp = 2'b10.
  - Mapped accesses return 2'b00.
- ap_start behaviour:
  - Set by a write to AP_CTRL with wstrb[0] & wdata[0].
  - Cleared on ap_ready unless auto_restart = 1.
  - A write of 0 does not clear it, except that a write of wdata[0] = 0 with auto_restart = 1 clears auto_restart only.
- done is set by ap_done and cleared by a read handshake on AP_CTRL.
- ISR[n] is set when IER[n] and its event pulse are both high.
- interrupt = GIE & |ISR.
- Simultaneous-event priorities:
  - Start write and ap_ready in the same cycle: start = 1.
  - ap_done and AP_CTRL read in the same cycle: done = 1, and the read returns the old value.
  - ISR event and ISR toggle write in the same cycle: set wins.
- Reset mid-transaction: both FSMs go to their RESET states and the pending response is dropped (bvalid = rvalid = 0). The host must retry.

## Timing
- Reset values: awready = arready = wready = bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, ap_start = 0, interrupt = 0, args = 0.
- awready and arready rise 1 cycle after areset deasserts.
- Write: AW handshake at cycle t, W handshake at t+1 or later. The register updates on the edge ending the W handshake, and bvalid is high the next cycle.
- Read: AR handshake at cycle t; rvalid and rdata are valid at t+1 and held until rready.
- Register to output latency: ap_start and args reflect a write 1 cycle after the W handshake. interrupt follows the ISR/GIE registers combinationally.
- With aclk_en low, no state changes and handshake outputs hold.

## Configuration
- KERNEL_CTRL_AUTO_RESTART_EN defined: AP_CTRL bit7 is implemented; when it is set, ap_start stays high across ap_ready.
- Not defined: bit7 reads 0, writes to it are ignored, and ap_start always clears on ap_ready.

## Test plan
- Reset, then write 0xDEADBEEF to 0x010 and 0x12345678 to 0x014 -> args[63:0] = 0x12345678DEADBEEF; reading both addresses back returns the same words with rresp = 0.
- Write 0x0000AA00 to 0x018 with wstrb = 4'b0010 after it held 0x11223344 -> reads 0x1122AA44.
- Write 0x1 to AP_CTRL, pulse ap_ready then ap_done -> ap_start drops the cycle after ap_ready. With GIE = 1 and IER = 1, interrupt = 1. The first AP_CTRL read returns bit1 = 1, the second returns bit1 = 0. Writing 0x1 to ISR drops interrupt.
- With auto-restart compiled in: write 0x81 to AP_CTRL, pulse ap_ready 3 times -> ap_start stays 1. Write 0x00 -> bit7 = 0; the next ap_ready clears ap_start.
- Read 0xFF0 with C_NUM_ARGS = 5 -> rresp = 2'b10, rdata = 0. Write to 0xFF0 -> bresp = 2'b10 and no register changes.
- Assert areset while in WRDATA -> bvalid stays 0 and the args are reset. A subsequent write completes normally.
